// File: rtl/mcpu_ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port RAM controller.
// Each granted access occupies one IDLE sampling cycle plus one ACCESS cycle.
module mcpu_ram_arbiter #(
  parameter int WORD_SIZE  = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [WORD_SIZE-1:0]  m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [WORD_SIZE-1:0]  m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [WORD_SIZE-1:0]  m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [WORD_SIZE-1:0]  m1_rdata,
  output logic                  ram_we,
  output logic                  ram_re,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [WORD_SIZE-1:0]  ram_wdata,
  input  logic [WORD_SIZE-1:0]  ram_rdata,
  output logic                  busy
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                  state;
  logic                    last_grant;  // 1 = m1 was granted most recently
  logic                    owner;       // requester of the access in flight
  logic                    pick_m1;
  logic                    sel_we;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [WORD_SIZE-1:0]    sel_wdata;

  // On a tie m1 wins only if m0 was the last one served.
  always_comb begin
    pick_m1   = m1_req && (!m0_req || !last_grant);
    sel_we    = pick_m1 ? m1_we    : m0_we;
    sel_addr  = pick_m1 ? m1_addr  : m0_addr;
    sel_wdata = pick_m1 ? m1_wdata : m0_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      m0_gnt     <= 1'b0;
      m1_gnt     <= 1'b0;
      m0_rvalid  <= 1'b0;
      m1_rvalid  <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
      ram_we     <= 1'b0;
      ram_re     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          m0_rvalid <= 1'b0;
          m1_rvalid <= 1'b0;
          if (m0_req || m1_req) begin
            owner      <= pick_m1;
            last_grant <= pick_m1;
            m0_gnt     <= !pick_m1;
            m1_gnt     <= pick_m1;
            busy       <= 1'b1;
            ram_addr   <= sel_addr;
            ram_wdata  <= sel_wdata;
            ram_we     <= sel_we;
            ram_re     <= !sel_we;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          m0_gnt <= 1'b0;
          m1_gnt <= 1'b0;
          busy   <= 1'b0;
          ram_we <= 1'b0;
          ram_re <= 1'b0;
          // ram_re doubles as the latched "this is a read" flag.
          if (ram_re) begin
            if (owner) begin
              m1_rdata  <= ram_rdata;
              m1_rvalid <= 1'b1;
            end else begin
              m0_rdata  <= ram_rdata;
              m0_rvalid <= 1'b1;
            end
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcpu_ram_arbiter.sv
// Directed bench for mcpu_ram_arbiter with a behavioural RAM and read-data scoreboard.
module tb_mcpu_ram_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       m0_req, m0_we, m1_req, m1_we;
  logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic       m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [7:0] m0_rdata, m1_rdata;
  logic       ram_we, ram_re, busy;
  logic [7:0] ram_addr, ram_wdata, ram_rdata;

  mcpu_ram_arbiter #(.WORD_SIZE(8), .ADDR_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_we(ram_we), .ram_re(ram_re), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [7:0] mem  [256];
  logic [7:0] expm [256];
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;
  assign ram_rdata = mem[ram_addr];

  int         passes = 0;
  int         total  = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic       prev_rd0 = 1'b0;
  logic       prev_rd1 = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Protocol monitor: rvalid model, scoreboard pop, output invariants.
  always @(negedge clk) begin
    if (reset) begin
      prev_rd0 = 1'b0;
      prev_rd1 = 1'b0;
    end else begin
      chk("m0_rvalid_follows_read", m0_rvalid, prev_rd0);
      chk("m1_rvalid_follows_read", m1_rvalid, prev_rd1);
      if (m0_rvalid) begin
        chk("q0_pending", q0.size() != 0, 1);
        if (q0.size() != 0) chk("m0_rdata", m0_rdata, q0.pop_front());
      end
      if (m1_rvalid) begin
        chk("q1_pending", q1.size() != 0, 1);
        if (q1.size() != 0) chk("m1_rdata", m1_rdata, q1.pop_front());
      end
      chk("we_re_exclusive", ram_we & ram_re, 0);
      chk("gnt_implies_busy", (m0_gnt | m1_gnt) & ~busy, 0);
      prev_rd0 = m0_gnt & ram_re;
      prev_rd1 = m1_gnt & ram_re;
    end
  end

  task automatic access(input bit m, input bit we, input logic [7:0] addr, input logic [7:0] data);
    bit ok = 0;
    if (!m) begin m0_req = 1; m0_we = we; m0_addr = addr; m0_wdata = data; end
    else    begin m1_req = 1; m1_we = we; m1_addr = addr; m1_wdata = data; end
    for (int i = 0; i < 8 && !ok; i++) begin
      @(negedge clk);
      if (m ? m1_gnt : m0_gnt) ok = 1;
    end
    if (!m) m0_req = 0; else m1_req = 0;
    chk("gnt_seen", ok, 1);
    if (ok) begin
      chk("ram_addr", ram_addr, addr);
      chk("ram_we", ram_we, we);
      chk("ram_re", ram_re, !we);
      if (we) begin
        chk("ram_wdata", ram_wdata, data);
        expm[addr] = data;
      end else if (m) q1.push_back(expm[addr]);
      else            q0.push_back(expm[addr]);
    end
  endtask

  initial begin
    logic [7:0] old30;
    bit ok;
    reset = 1;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    for (int i = 0; i < 256; i++) begin mem[i] = '0; expm[i] = '0; end
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_gnt", {m0_gnt, m1_gnt}, 0);
    chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
    chk("rst_ram_we_re", {ram_we, ram_re}, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_rdata", {m0_rdata, m1_rdata}, 0);
    reset = 0;

    // m0 write then m1 read of the same word
    access(0, 1, 8'h10, 8'hA5);
    access(1, 0, 8'h10, 8'h00);
    repeat (2) @(negedge clk);
    chk("m1_rdata_after_read", m1_rdata, 8'hA5);
    chk("m0_rdata_untouched", m0_rdata, 8'h00);

    // Both requesters held: grants alternate starting with m0
    m0_req = 1; m0_we = 1; m0_addr = 8'h20; m0_wdata = 8'h11;
    m1_req = 1; m1_we = 1; m1_addr = 8'h21; m1_wdata = 8'h22;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rr_m0_gnt", m0_gnt, (i % 4) == 0);
      chk("rr_m1_gnt", m1_gnt, (i % 4) == 2);
      if ((i % 4) == 0) chk("rr_addr_m0", ram_addr, 8'h20);
      if ((i % 4) == 2) chk("rr_addr_m1", ram_addr, 8'h21);
    end
    m0_req = 0; m1_req = 0;
    expm[8'h20] = 8'h11; expm[8'h21] = 8'h22;
    repeat (2) @(negedge clk);
    chk("mem_20", mem[8'h20], 8'h11);
    chk("mem_21", mem[8'h21], 8'h22);

    // Full address sweep: fill via m1, read back via m0, then wrap 0xFF -> 0x00
    for (int a = 0; a < 256; a++) access(1, 1, 8'(a), 8'($urandom_range(0, 255)));
    for (int a = 0; a < 256; a++) access(0, 0, 8'(a), 8'h00);
    access(0, 0, 8'hFF, 8'h00);
    access(0, 0, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("m1_rdata_held", m1_rdata, 8'hA5);

    // Reset in the middle of a write access
    old30 = expm[8'h30];
    m0_req = 1; m0_we = 1; m0_addr = 8'h30; m0_wdata = ~old30;
    ok = 0;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(negedge clk);
      if (m0_gnt) ok = 1;
    end
    chk("rst_mid_gnt_seen", ok, 1);
    chk("rst_mid_we_before", ram_we, 1);
    #1 reset = 1;
    #1;
    chk("rst_mid_ram_we", ram_we, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_gnt", m0_gnt, 0);
    m0_req = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_no_gnt", {m0_gnt, m1_gnt, busy}, 0);
    end
    chk("mem_30_unwritten", mem[8'h30], old30);
    access(0, 0, 8'h30, 8'h00);
    repeat (3) @(negedge clk);
    chk("q0_final_drained", q0.size(), 0);
    chk("q1_final_drained", q1.size(), 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
